// File: rtl/universal_shift_reg_n.sv
// Parametrised universal shift register with a 3-bit operation set and a
// burst engine that repeats a latched operation for a programmed cycle count.
module universal_shift_reg_n #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       sel,
  input  logic             en,
  input  logic [WIDTH-1:0] p_in,
  input  logic             s_right_in,
  input  logic             s_left_in,
  input  logic             start,
  input  logic [CNT_W-1:0] cnt_in,
  output logic [WIDTH-1:0] p_out,
  output logic             s_right_out,
  output logic             s_left_out,
  output logic             busy,
  output logic             done
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             r_state;
  logic [WIDTH-1:0]   r_data;
  logic [2:0]         r_op;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_done;
  logic [2:0]         w_op;
  logic [WIDTH-1:0]   w_next;

  // The burst engine reuses the same datapath, just fed from the latched op.
  assign w_op = (r_state == RUN) ? r_op : sel;

  always_comb begin
    w_next = r_data;
    case (w_op)
      3'b001:  w_next = {s_right_in, r_data[WIDTH-1:1]};
      3'b010:  w_next = {r_data[WIDTH-2:0], s_left_in};
      3'b011:  w_next = p_in;
      3'b100:  w_next = {r_data[0], r_data[WIDTH-1:1]};
      3'b101:  w_next = {r_data[WIDTH-2:0], r_data[WIDTH-1]};
      3'b110:  w_next = {r_data[WIDTH-1], r_data[WIDTH-1:1]};
      default: w_next = r_data;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_data  <= '0;
      r_op    <= 3'b000;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            // A zero-length burst still completes the handshake.
            if (cnt_in != '0) begin
              r_op    <= sel;
              r_cnt   <= cnt_in;
              r_state <= RUN;
            end else begin
              r_done <= 1'b1;
            end
          end else if (en) begin
            r_data <= w_next;
          end
        end
        RUN: begin
          r_data <= w_next;
          r_cnt  <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            r_state <= IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign p_out       = r_data;
  assign s_right_out = r_data[0];
  assign s_left_out  = r_data[WIDTH-1];
  assign busy        = (r_state == RUN);
  assign done        = r_done;

endmodule
